// File: rtl/wb_arbiter_if.sv
// Bus bundle between the writeback sources, the issue-stage claim port and
// the register-file write port of wb_arbiter.
interface wb_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  a_valid_i;
  logic                  a_ready_o;
  logic [ADDR_WIDTH-1:0] a_addr_i;
  logic [WIDTH-1:0]      a_data_i;

  logic                  b_valid_i;
  logic                  b_ready_o;
  logic [ADDR_WIDTH-1:0] b_addr_i;
  logic [WIDTH-1:0]      b_data_i;

  logic                  claim_i;
  logic [ADDR_WIDTH-1:0] claim_addr_i;

  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [WIDTH-1:0]      wr_data_o;
  logic [NREG-1:0]       busy_o;

  // master: the environment (sources, issue stage, regfile observer)
  modport master (
    output a_valid_i, a_addr_i, a_data_i,
    output b_valid_i, b_addr_i, b_data_i,
    output claim_i, claim_addr_i,
    input  a_ready_o, b_ready_o,
    input  wr_en_o, wr_addr_o, wr_data_o, busy_o
  );

  modport slave (
    input  a_valid_i, a_addr_i, a_data_i,
    input  b_valid_i, b_addr_i, b_data_i,
    input  claim_i, claim_addr_i,
    output a_ready_o, b_ready_o,
    output wr_en_o, wr_addr_o, wr_data_o, busy_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-source round-robin writeback arbiter with a registered regfile write
// port and a per-register pending-write scoreboard.
module wb_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  wb_arbiter_if.slave bus
);
  localparam int NREG = 1 << ADDR_WIDTH;

  localparam logic [0:0] PTR_A = 1'b0;
  localparam logic [0:0] PTR_B = 1'b1;

  logic [0:0]            ptr_q;
  logic                  grant_a;
  logic                  grant_b;
  logic                  accept;
  logic                  zero_hit;
  logic                  claim_ok;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;

  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [WIDTH-1:0]      wr_data_q;
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_d;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant_a  = bus.a_valid_i && (!bus.b_valid_i || (ptr_q == PTR_A));
    grant_b  = bus.b_valid_i && (!bus.a_valid_i || (ptr_q == PTR_B));
    accept   = grant_a || grant_b;
    sel_addr = grant_b ? bus.b_addr_i : bus.a_addr_i;
    sel_data = grant_b ? bus.b_data_i : bus.a_data_i;
    zero_hit = (ZERO_REG != 0) && (sel_addr == '0);
    claim_ok = bus.claim_i && !((ZERO_REG != 0) && (bus.claim_addr_i == '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= PTR_A;
    end else if (grant_a) begin
      ptr_q <= PTR_B;
    end else if (grant_b) begin
      ptr_q <= PTR_A;
    end
  end

  // Writes to a hardwired-zero register are accepted but never enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= accept && !zero_hit;
      if (accept) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  // Clear first, then set, so a coincident claim keeps the register pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end
    if (claim_ok) begin
      busy_d[bus.claim_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.a_ready_o = grant_a;
  assign bus.b_ready_o = grant_b;
  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
  assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a transaction-level model checked every
// cycle, plus directed vectors with literal expected values.
module tb_wb_arbiter;
  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  wb_arbiter #(
    .WIDTH(WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG(1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  bit          m_favour_b = 1'b0;
  bit          m_wr_en    = 1'b0;
  logic [4:0]  m_wr_addr  = '0;
  logic [31:0] m_wr_data  = '0;
  logic [31:0] m_busy     = '0;

  function automatic bit exp_a_ready();
    return bus.a_valid_i && !(bus.b_valid_i && m_favour_b);
  endfunction

  function automatic bit exp_b_ready();
    return bus.b_valid_i && !(bus.a_valid_i && !m_favour_b);
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the winner's write shows up one edge later; scoreboard clears the
  // currently-written register, then applies the claim.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_favour_b = 1'b0;
      m_wr_en    = 1'b0;
      m_wr_addr  = '0;
      m_wr_data  = '0;
      m_busy     = '0;
    end else begin
      bit ga;
      bit gb;
      ga = exp_a_ready();
      gb = exp_b_ready();
      if (m_wr_en) m_busy[m_wr_addr] = 1'b0;
      if (bus.claim_i && bus.claim_addr_i != 5'd0) m_busy[bus.claim_addr_i] = 1'b1;
      if (ga) begin
        m_favour_b = 1'b1;
        m_wr_en    = (bus.a_addr_i != 5'd0);
        m_wr_addr  = bus.a_addr_i;
        m_wr_data  = bus.a_data_i;
      end else if (gb) begin
        m_favour_b = 1'b0;
        m_wr_en    = (bus.b_addr_i != 5'd0);
        m_wr_addr  = bus.b_addr_i;
        m_wr_data  = bus.b_data_i;
      end else begin
        m_wr_en = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check_output("model a_ready", 64'(bus.a_ready_o), 64'(exp_a_ready()));
    check_output("model b_ready", 64'(bus.b_ready_o), 64'(exp_b_ready()));
    check_output("model wr_en",   64'(bus.wr_en_o),   64'(m_wr_en));
    check_output("model wr_addr", 64'(bus.wr_addr_o), 64'(m_wr_addr));
    check_output("model wr_data", 64'(bus.wr_data_o), 64'(m_wr_data));
    check_output("model busy",    64'(bus.busy_o),    64'(m_busy));
  end

  task automatic apply_stimulus(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                                input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                                input bit cl, input logic [4:0] ca);
    bus.a_valid_i    = av;
    bus.a_addr_i     = aa;
    bus.a_data_i     = ad;
    bus.b_valid_i    = bv;
    bus.b_addr_i     = ba;
    bus.b_data_i     = bd;
    bus.claim_i      = cl;
    bus.claim_addr_i = ca;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle();
    #1 rst_n = 1'b0;
    #2;
    check_output("reset wr_en",   64'(bus.wr_en_o),   64'd0);
    check_output("reset wr_addr", 64'(bus.wr_addr_o), 64'd0);
    check_output("reset wr_data", 64'(bus.wr_data_o), 64'd0);
    check_output("reset busy",    64'(bus.busy_o),    64'd0);
    repeat (2) cycle();
    rst_n = 1'b1;

    // Single requester A, first cycle after release
    apply_stimulus(1'b1, 5'd3, 32'h1111_1111, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    check_output("a-only a_ready", 64'(bus.a_ready_o), 64'd1);
    check_output("a-only b_ready", 64'(bus.b_ready_o), 64'd0);
    cycle();
    idle();
    check_output("a-only wr_en",   64'(bus.wr_en_o),   64'd1);
    check_output("a-only wr_addr", 64'(bus.wr_addr_o), 64'd3);
    check_output("a-only wr_data", 64'(bus.wr_data_o), 64'h1111_1111);
    cycle();
    check_output("a-only wr_en drop", 64'(bus.wr_en_o),   64'd0);
    check_output("a-only addr hold",  64'(bus.wr_addr_o), 64'd3);

    // Contention straight after a fresh reset: A,B,A,B
    rst_n = 1'b0;
    #1;
    check_output("async reset wr_addr", 64'(bus.wr_addr_o), 64'd0);
    check_output("async reset wr_data", 64'(bus.wr_data_o), 64'd0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 5'd1, 32'hA000_0000 + 32'(i), 1'b1, 5'd2, 32'hB000_0000 + 32'(i),
                     1'b0, 5'd0);
      #1;
      check_output("contend a_ready", 64'(bus.a_ready_o), (i % 2 == 0) ? 64'd1 : 64'd0);
      check_output("contend b_ready", 64'(bus.b_ready_o), (i % 2 == 1) ? 64'd1 : 64'd0);
      cycle();
      check_output("contend wr_en",   64'(bus.wr_en_o), 64'd1);
      check_output("contend wr_addr", 64'(bus.wr_addr_o), (i % 2 == 0) ? 64'd1 : 64'd2);
      check_output("contend wr_data", 64'(bus.wr_data_o),
                   (i % 2 == 0) ? 64'(32'hA000_0000 + 32'(i)) : 64'(32'hB000_0000 + 32'(i)));
    end
    idle();

    // Hardwired zero register, including an ignored claim of register 0
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0);
    #1;
    check_output("zero b_ready", 64'(bus.b_ready_o), 64'd1);
    cycle();
    idle();
    check_output("zero wr_en", 64'(bus.wr_en_o), 64'd0);
    check_output("zero busy",  64'(bus.busy_o),  64'd0);

    // Scoreboard set, re-claim, clear, coincident claim+clear, clear of idle reg
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    cycle();
    check_output("claim5 busy", 64'(bus.busy_o), 64'h20);
    cycle();
    check_output("reclaim5 busy", 64'(bus.busy_o), 64'h20);
    apply_stimulus(1'b1, 5'd5, 32'h0000_0055, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    cycle();
    idle();
    check_output("wr5 wr_en", 64'(bus.wr_en_o), 64'd1);
    check_output("wr5 busy still set", 64'(bus.busy_o), 64'h20);
    cycle();
    check_output("wr5 busy cleared", 64'(bus.busy_o), 64'h0);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    cycle();
    apply_stimulus(1'b1, 5'd5, 32'h0000_0056, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    cycle();
    check_output("wr5b wr_en", 64'(bus.wr_en_o), 64'd1);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
    cycle();
    idle();
    check_output("set wins busy", 64'(bus.busy_o), 64'h20);
    cycle();
    check_output("set wins hold", 64'(bus.busy_o), 64'h20);
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0);
    cycle();
    idle();
    cycle();
    check_output("clear idle reg busy", 64'(bus.busy_o), 64'h20);

    // Reset in the middle of an accepted transfer
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
    cycle();
    check_output("claim12 busy", 64'(bus.busy_o), 64'h1020);
    apply_stimulus(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    check_output("midop wr_en", 64'(bus.wr_en_o), 64'd0);
    check_output("midop busy",  64'(bus.busy_o),  64'd0);
    idle();
    cycle();
    rst_n = 1'b1;
    check_output("post-release wr_en",   64'(bus.wr_en_o),   64'd0);
    check_output("post-release wr_data", 64'(bus.wr_data_o), 64'd0);
    apply_stimulus(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2, 1'b0, 5'd0);
    #1;
    check_output("post-reset grant a", 64'(bus.a_ready_o), 64'd1);
    check_output("post-reset grant b", 64'(bus.b_ready_o), 64'd0);
    cycle();
    idle();
    check_output("post-reset wr_addr", 64'(bus.wr_addr_o), 64'd1);

    // Ten idle cycles keep the last write's address and data
    apply_stimulus(1'b1, 5'd17, 32'h0BAD_F00D, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    cycle();
    idle();
    check_output("idle seed wr_en", 64'(bus.wr_en_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_output("idle wr_en",   64'(bus.wr_en_o),   64'd0);
      check_output("idle wr_addr", 64'(bus.wr_addr_o), 64'd17);
      check_output("idle wr_data", 64'(bus.wr_data_o), 64'h0BAD_F00D);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
